rca_slice_sequencer: RTL and testbench

- Multi-cycle wide adder controller. One WIDTH-bit ripple-carry slice, built internally from full_adder cells, is time-multiplexed across SLICES operand words to produce a WIDTH*SLICES-bit sum.
- The carry is registered between slices: least-significant slice first, one slice per clock.
- Sits between the operand source and the result consumer wherever a full-width combinational ripple chain would miss timing.

---
 rtl/rca_slice_sequencer.sv | 111 +++++++++++
 tb/tb_rca_slice_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_slice_sequencer.sv
// Multi-cycle wide adder: one WIDTH-bit ripple-carry slice reused across SLICES
// operand words, least-significant first, with the carry registered between slices.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_slice_sequencer #(
    parameter int WIDTH  = 42,
    parameter int SLICES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [WIDTH*SLICES-1:0]   i_op_a,
    input  logic [WIDTH*SLICES-1:0]   i_op_b,
    input  logic                      i_carry_in,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [WIDTH*SLICES:0]     o_result
);
    localparam int N  = WIDTH * SLICES;
    localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [N-1:0]    a_reg, b_reg, sum_reg, sum_merged;
    logic            carry_reg;
    logic [CW-1:0]   cnt;
    logic            last;

    logic [WIDTH-1:0] sl_a, sl_b, sl_s;
    logic [WIDTH:0]   c;

    assign last = (cnt == LAST);
    assign sl_a = a_reg[int'(cnt)*WIDTH +: WIDTH];
    assign sl_b = b_reg[int'(cnt)*WIDTH +: WIDTH];
    assign c[0] = carry_reg;

    full_adder u_fa [WIDTH-1:0] (
        .a  (sl_a),
        .b  (sl_b),
        .ci (c[WIDTH-1:0]),
        .s  (sl_s),
        .co (c[WIDTH:1])
    );

    // Final result needs the current slice merged in, not the stale sum_reg.
    always_comb begin
        sum_merged = sum_reg;
        sum_merged[int'(cnt)*WIDTH +: WIDTH] = sl_s;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (i_start) state_n = RUN;
            RUN:     if (last)    state_n = DONE;
            DONE:                 state_n = IDLE;
            default:              state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_n;
            o_busy <= (state_n != IDLE);
            o_done <= (state_n == DONE);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            o_result  <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    a_reg     <= i_op_a;
                    b_reg     <= i_op_b;
                    carry_reg <= i_carry_in;
                    cnt       <= '0;
                end
                RUN: begin
                    sum_reg   <= sum_merged;
                    carry_reg <= c[WIDTH];
                    if (last) o_result <= {c[WIDTH], sum_merged};
                    else      cnt      <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Self-checking bench: directed scenarios plus random back-to-back streams for
// SLICES=4 and SLICES=1, compared against plain wide-integer addition.

module tb_rca_slice_sequencer;
    localparam int W  = 42;
    localparam int S  = 4;
    localparam int N  = W * S;
    localparam int N1 = W;

    logic          clk, rst;
    logic          start, cin, busy, done;
    logic [N-1:0]  a, b;
    logic [N:0]    res;
    logic          start1, cin1, busy1, done1;
    logic [N1-1:0] a1, b1;
    logic [N1:0]   res1;

    int n_tests = 0;
    int n_fail  = 0;

    rca_slice_sequencer #(.WIDTH(W), .SLICES(S)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op_a(a), .i_op_b(b),
        .i_carry_in(cin), .o_busy(busy), .o_done(done), .o_result(res)
    );

    rca_slice_sequencer #(.WIDTH(W), .SLICES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_op_a(a1), .i_op_b(b1),
        .i_carry_in(cin1), .o_busy(busy1), .o_done(done1), .o_result(res1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    function automatic logic [N:0] ref_add(logic [N-1:0] x, logic [N-1:0] y, logic c);
        return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    endfunction

    function automatic logic [N1:0] ref_add1(logic [N1-1:0] x, logic [N1-1:0] y, logic c);
        return {1'b0, x} + {1'b0, y} + {{N1{1'b0}}, c};
    endfunction

    // Slices biased toward all-ones / zero so long carry ripples occur often.
    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] v;
        logic [63:0]  t;
        v = '0;
        for (int i = 0; i < S; i++) begin
            t = {$urandom, $urandom};
            case ($urandom % 4)
                0:       v[i*W +: W] = '1;
                1:       v[i*W +: W] = '0;
                default: v[i*W +: W] = t[W-1:0];
            endcase
        end
        return v;
    endfunction

    // Returns at the falling edge just after the accepting edge E0.
    task automatic drive_start(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges from E0 until o_done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 20);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #10;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b res=%h, want 0/0/0", busy, done, res);
        end
        n_tests++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== '0) begin
            n_fail++;
            $display("FAIL reset_s1: busy=%b done=%b res=%h, want 0/0/0", busy1, done1, res1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        drive_start(168'd5, 168'd3, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_run: busy=%b done=%b, want 1/0", busy, done);
        end
        wait_done(cyc);
        n_tests++;
        if (cyc !== S) begin
            n_fail++;
            $display("FAIL basic_latency: done after %0d cycles, want %0d", cyc, S);
        end
        n_tests++;
        if (res !== 169'd8 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_result: res=%h busy=%b, want 8/1", res, busy);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    task automatic test_ripple();
        int cyc;
        logic [N-1:0] ones;
        logic [N:0]   e;
        ones = '1;
        e = '0;
        e[N] = 1'b1;
        drive_start(ones, '0, 1'b1);
        wait_done(cyc);
        n_tests++;
        if (res !== e || cyc !== S) begin
            n_fail++;
            $display("FAIL ripple_cin: res=%h cyc=%0d, want %h/%0d", res, cyc, e, S);
        end
        drive_start(ones, 168'd1, 1'b0);
        wait_done(cyc);
        n_tests++;
        if (res !== e || cyc !== S) begin
            n_fail++;
            $display("FAIL ripple_b1: res=%h cyc=%0d, want %h/%0d", res, cyc, e, S);
        end
    endtask

    task automatic test_boundary();
        int cyc;
        logic [N-1:0] x;
        logic [N:0]   e;
        x = '0;
        x[W-1:0] = '1;
        e = '0;
        e[W] = 1'b1;
        drive_start(x, 168'd1, 1'b0);
        wait_done(cyc);
        n_tests++;
        if (res !== e || cyc !== S) begin
            n_fail++;
            $display("FAIL slice_boundary: res=%h cyc=%0d, want %h/%0d", res, cyc, e, S);
        end
    endtask

    // Expects the previous result to be 2^42 (left by test_boundary).
    task automatic test_ignored();
        logic [N:0] prev;
        logic       bad;
        prev = '0;
        prev[W] = 1'b1;
        drive_start(168'd100, 168'd23, 1'b0);
        for (int i = 1; i < S; i++) begin
            start = i[0];
            a = rand_op(); b = rand_op(); cin = 1'b1;
            @(negedge clk);
            n_tests++;
            if (res !== prev || done !== 1'b0) begin
                n_fail++;
                $display("FAIL ignored_hold%0d: res=%h done=%b, want %h/0", i, res, done, prev);
            end
        end
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || res !== 169'd123) begin
            n_fail++;
            $display("FAIL ignored_result: done=%b res=%h, want 1/123", done, res);
        end
        start = 1'b1;
        a = rand_op(); b = rand_op();
        @(negedge clk);
        start = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (bad !== 1'b0 || res !== 169'd123) begin
            n_fail++;
            $display("FAIL ignored_no_extra: extra activity=%b res=%h, want 0/123", bad, res);
        end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        logic bad;
        drive_start(168'd55, 168'd66, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b res=%h, want 0/0/0", busy, done, res);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abandon: activity after reset=%b, want 0", bad);
        end
        drive_start(168'd7, 168'd9, 1'b0);
        wait_done(cyc);
        n_tests++;
        if (res !== 169'd16 || cyc !== S) begin
            n_fail++;
            $display("FAIL reset_mid_next: res=%h cyc=%0d, want 16/%0d", res, cyc, S);
        end
    endtask

    // Start held high: accepts at edges 0, P, 2P..., done seen after edge kP+S.
    task automatic test_back_to_back(input int ops);
        localparam int P = S + 2;
        logic [N:0] exp_q[$];
        logic [N:0] e;
        @(negedge clk);
        start = 1'b1;
        for (int j = 0; j < P * ops; j++) begin
            a = rand_op(); b = rand_op(); cin = 1'($urandom);
            if (j % P == 0) exp_q.push_back(ref_add(a, b, cin));
            @(negedge clk);
            n_tests++;
            if (done !== (j % P == S)) begin
                n_fail++;
                $display("FAIL b2b_done edge %0d: done=%b, want %b", j, done, (j % P == S));
            end
            if (j % P == S) begin
                e = exp_q.pop_front();
                n_tests++;
                if (res !== e) begin
                    n_fail++;
                    $display("FAIL b2b_result edge %0d: res=%h, want %h", j, res, e);
                end
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back_s1(input int ops);
        logic [N1:0]  exp_q[$];
        logic [N1:0]  e;
        logic [N-1:0] t;
        @(negedge clk);
        start1 = 1'b1;
        for (int j = 0; j < 3 * ops; j++) begin
            t = rand_op(); a1 = t[N1-1:0];
            t = rand_op(); b1 = t[N1-1:0];
            cin1 = 1'($urandom);
            if (j % 3 == 0) exp_q.push_back(ref_add1(a1, b1, cin1));
            @(negedge clk);
            n_tests++;
            if (done1 !== (j % 3 == 1) || busy1 !== (j % 3 != 2)) begin
                n_fail++;
                $display("FAIL s1_timing edge %0d: done=%b busy=%b, want %b/%b",
                         j, done1, busy1, (j % 3 == 1), (j % 3 != 2));
            end
            if (j % 3 == 1) begin
                e = exp_q.pop_front();
                n_tests++;
                if (res1 !== e) begin
                    n_fail++;
                    $display("FAIL s1_result edge %0d: res=%h, want %h", j, res1, e);
                end
            end
        end
        start1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_boundary();
        test_ignored();
        test_reset_mid();
        test_back_to_back(1000);
        test_back_to_back_s1(300);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
